muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
- Iterative multiply/divide unit for the EX stage of the 5-stage pipelined CPU.
- Produces HI/LO results for MULT, MULTU, DIV and DIVU, with word width set by XLEN.
- Holds the pipeline through a busy/stall handshake: busy drives the hazard unit's PC_Write, IF_ID_write and control-zeroing path.
- Implements radix-2 shift-add multiplication and restoring division, followed by a one-cycle sign-fixup state.

Parameters:
- XLEN, 32, operand and result width (power of two, minimum 8).
- CNT_W, $clog2(XLEN)+1, width of the iteration counter; derived, do not override.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- start  in  1  request a new operation; sampled only in IDLE
- op  in  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV
- srcA  in  XLEN  multiplicand / dividend
- srcB  in  XLEN  multiplier / divisor
- busy  out  1  high while an operation is in flight (stall request)
- done  out  1  one-cycle pulse when hi/lo become valid
- div_by_zero  out  1  valid with done; high when a DIV/DIVU had srcB==0
- hi  out  XLEN  product upper half / remainder
- lo  out  XLEN  product lower half / quotient

Behaviour:
- Reset: state=IDLE; busy=0, done=0, div_by_zero=0, hi=0, lo=0, counter=0. Reset mid-operation aborts immediately; the next cycle is IDLE with all outputs 0.
- States: IDLE, MUL, DIV, FIX.
- IDLE, start=1, op[1]=0: latch |srcA| and |srcB| (magnitudes for MULT, raw for MULTU); latch result sign = srcA[XLEN-1]^srcB[XLEN-1] (MULT only); go to MUL.
- IDLE, start=1, op[1]=1, srcB!=0: latch magnitudes; quotient sign = sA^sB; remainder sign = sA (DIV only); go to DIV.
- IDLE, start=1, op[1]=1, srcB==0: go straight to FIX with hi=srcA, lo=all ones, dbz flag set.
- MUL: one shift-add step per cycle over a 2*XLEN accumulator; counter runs 0..XLEN-1; after XLEN steps go to FIX.
- DIV: one restoring step per cycle (shift remainder, trial subtract, set quotient bit); after XLEN steps go to FIX.
- FIX: negate results whose latched sign is set. For MULT, negate the full 2*XLEN product. For DIV, negate quotient and remainder independently. Register into hi/lo, pulse done=1, go to IDLE.
- Latency: start sampled at edge k. busy=1 from k+1 until done rises. MUL/DIV: done=1 during cycle k+XLEN+2. Divide-by-zero: done=1 during cycle k+2.
- busy=1 in MUL, DIV and FIX; busy=0 in IDLE, including the cycle in which done=1.
- start while busy is ignored: no queueing, no error.
- start in the same cycle as done (state IDLE) is accepted normally.
- hi/lo hold their value until the next FIX. Operand changes after the start cycle have no effect.
- Signed overflow, DIV of -2^(XLEN-1) by -1: lo=-2^(XLEN-1) (wrapped), hi=0, div_by_zero=0.
- Arithmetic is modulo 2^XLEN per output word. The MUL accumulator is 2*XLEN wide; the DIV remainder register is XLEN+1 wide.

Optional Feature:
- Macro MULDIV_FLUSH_EN.
- When defined: adds input port flush (1 bit). flush=1 in any state returns to IDLE next cycle with busy=0, done=0 and hi/lo unchanged. flush has priority over start, and also blocks the done pulse in FIX.
- When undefined: no flush port; every accepted operation completes.

Test Plan:
- MULTU, srcA=0xFFFFFFFF, srcB=2 -> done at k+34; hi=0x00000001, lo=0xFFFFFFFE; busy high for exactly 33 cycles.
- MULT, srcA=-3 (0xFFFFFFFD), srcB=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB (-21).
- DIV, srcA=-7, srcB=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1); DIVU, srcA=100, srcB=7 -> lo=14, hi=2.
- DIVU, srcA=0x1234, srcB=0 -> done at k+2, div_by_zero=1, hi=0x1234, lo=0xFFFFFFFF.
- Assert rst at cycle 10 of a MUL; also pulse start mid-operation -> IDLE next cycle with all outputs 0; the mid-operation start has no effect and done never pulses.
- With MULDIV_FLUSH_EN: flush at cycle 5 of a DIV with hi/lo holding an earlier result -> IDLE, no done pulse, hi/lo keep the earlier result; a new start the cycle after flush completes normally.

Source files
------------

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit: radix-2 shift-add multiply, restoring divide, one-cycle sign fixup.
// Define MULDIV_FLUSH_EN to add a flush input that aborts the operation in flight.
module muldiv_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN) + 1
) (
    input  logic            clk,
    input  logic            rst,
`ifdef MULDIV_FLUSH_EN
    input  logic            flush,
`endif
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] srcA,
    input  logic [XLEN-1:0] srcB,
    output logic            busy,
    output logic            done,
    output logic            div_by_zero,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_FIX
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [XLEN-1:0]   opnd_q, opnd_d;     // multiplicand or divisor magnitude
    logic [2*XLEN-1:0] acc_q, acc_d;       // product; low half doubles as dividend/quotient shifter
    logic [XLEN:0]     rem_q, rem_d;
    logic              is_mul_q, is_mul_d;
    logic              neg_lo_q, neg_lo_d; // product sign, or quotient sign
    logic              neg_hi_q, neg_hi_d; // remainder sign
    logic              zero_div_q, zero_div_d;
    logic [XLEN-1:0]   hi_q, hi_d;
    logic [XLEN-1:0]   lo_q, lo_d;
    logic              done_q, done_d;
    logic              div_by_zero_q, div_by_zero_d;

    logic flush_w;
`ifdef MULDIV_FLUSH_EN
    assign flush_w = flush;
`else
    assign flush_w = 1'b0;
`endif

    logic            sign_a, sign_b;
    logic [XLEN-1:0] mag_a, mag_b;

    assign sign_a = op[0] & srcA[XLEN-1];
    assign sign_b = op[0] & srcB[XLEN-1];
    assign mag_a  = sign_a ? -srcA : srcA;
    assign mag_b  = sign_b ? -srcB : srcB;

    logic [XLEN:0] mul_sum;
    assign mul_sum = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);

    // Two extra bits keep the trial difference's sign visible without overflow.
    logic [XLEN+1:0] rem_sh, rem_trial;
    assign rem_sh    = {rem_q, acc_q[XLEN-1]};
    assign rem_trial = rem_sh - {2'b00, opnd_q};

    logic last_step;
    assign last_step = (cnt_q == CNT_W'(XLEN - 1));

    always_comb begin
        // NOTE: every next-state signal gets its default first, so no path can infer a latch.
        state_d       = state_q;
        cnt_d         = cnt_q;
        opnd_d        = opnd_q;
        acc_d         = acc_q;
        rem_d         = rem_q;
        is_mul_d      = is_mul_q;
        neg_lo_d      = neg_lo_q;
        neg_hi_d      = neg_hi_q;
        zero_div_d    = zero_div_q;
        hi_d          = hi_q;
        lo_d          = lo_q;
        done_d        = 1'b0;
        div_by_zero_d = div_by_zero_q;

        if (flush_w) begin
            state_d = S_IDLE;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        cnt_d    = '0;
                        is_mul_d = ~op[1];
                        if (!op[1]) begin
                            opnd_d     = mag_a;
                            acc_d      = {{XLEN{1'b0}}, mag_b};
                            rem_d      = '0;
                            neg_lo_d   = sign_a ^ sign_b;
                            neg_hi_d   = 1'b0;
                            zero_div_d = 1'b0;
                            state_d    = S_MUL;
                        end else if (srcB == '0) begin
                            opnd_d     = '0;
                            acc_d      = {{XLEN{1'b0}}, {XLEN{1'b1}}};
                            rem_d      = {1'b0, srcA};
                            neg_lo_d   = 1'b0;
                            neg_hi_d   = 1'b0;
                            zero_div_d = 1'b1;
                            state_d    = S_FIX;
                        end else begin
                            opnd_d     = mag_b;
                            acc_d      = {{XLEN{1'b0}}, mag_a};
                            rem_d      = '0;
                            neg_lo_d   = sign_a ^ sign_b;
                            neg_hi_d   = sign_a;
                            zero_div_d = 1'b0;
                            state_d    = S_DIV;
                        end
                    end
                end

                S_MUL: begin
                    acc_d = {mul_sum, acc_q[XLEN-1:1]};
                    if (last_step) begin
                        cnt_d   = '0;
                        state_d = S_FIX;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end

                S_DIV: begin
                    rem_d = rem_trial[XLEN+1] ? rem_sh[XLEN:0] : rem_trial[XLEN:0];
                    acc_d = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-2:0], ~rem_trial[XLEN+1]};
                    if (last_step) begin
                        cnt_d   = '0;
                        state_d = S_FIX;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end

                S_FIX: begin
                    if (is_mul_q) begin
                        {hi_d, lo_d} = neg_lo_q ? -acc_q : acc_q;
                    end else begin
                        lo_d = neg_lo_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
                        hi_d = neg_hi_q ? -rem_q[XLEN-1:0] : rem_q[XLEN-1:0];
                    end
                    done_d        = 1'b1;
                    div_by_zero_d = zero_div_q;
                    state_d       = S_IDLE;
                end

                default: state_d = S_IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples the same pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            opnd_q        <= '0;
            acc_q         <= '0;
            rem_q         <= '0;
            is_mul_q      <= 1'b0;
            neg_lo_q      <= 1'b0;
            neg_hi_q      <= 1'b0;
            zero_div_q    <= 1'b0;
            hi_q          <= '0;
            lo_q          <= '0;
            done_q        <= 1'b0;
            div_by_zero_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            opnd_q        <= opnd_d;
            acc_q         <= acc_d;
            rem_q         <= rem_d;
            is_mul_q      <= is_mul_d;
            neg_lo_q      <= neg_lo_d;
            neg_hi_q      <= neg_hi_d;
            zero_div_q    <= zero_div_d;
            hi_q          <= hi_d;
            lo_q          <= lo_d;
            done_q        <= done_d;
            div_by_zero_q <= div_by_zero_d;
        end
    end

    assign busy        = (state_q != S_IDLE);
    assign done        = done_q;
    assign div_by_zero = div_by_zero_q;
    assign hi          = hi_q;
    assign lo          = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed literal cases plus randomized traffic
// compared every cycle against a timeline/arithmetic model (XLEN = 32).
`timescale 1ns/1ps
module tb_muldiv_unit;
    localparam int XLEN = 32;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] srcA = '0;
    logic [31:0] srcB = '0;
    logic        busy, done, div_by_zero;
    logic [31:0] hi, lo;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    muldiv_unit #(.XLEN(XLEN)) dut (
        .clk(clk),
        .rst(rst),
`ifdef MULDIV_FLUSH_EN
        .flush(flush),
`endif
        .start(start),
        .op(op),
        .srcA(srcA),
        .srcB(srcB),
        .busy(busy),
        .done(done),
        .div_by_zero(div_by_zero),
        .hi(hi),
        .lo(lo)
    );

    int cyc = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", name, act, exp, cyc);
        end
    endtask

    // Arithmetic reference: plain 64-bit products and C-style truncating division.
    function automatic void ref_calc(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                     output logic [31:0] rh, output logic [31:0] rl, output logic rz);
        longint          sa, sb, q, r;
        longint unsigned p;
        rz = 1'b0;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (o)
            2'b00: begin
                p  = {32'b0, a} * {32'b0, b};
                rh = p[63:32];
                rl = p[31:0];
            end
            2'b01: begin
                q  = sa * sb;
                rh = q[63:32];
                rl = q[31:0];
            end
            default: begin
                if (b == 32'd0) begin
                    rh = a;
                    rl = 32'hFFFF_FFFF;
                    rz = 1'b1;
                end else if (o == 2'b10) begin
                    rl = a / b;
                    rh = a % b;
                end else begin
                    q  = sa / sb;
                    r  = sa % sb;
                    rl = q[31:0];
                    rh = r[31:0];
                end
            end
        endcase
    endfunction

    // Model of what the outputs must show in the cycle after each edge.
    logic        m_valid = 1'b0, m_pending = 1'b0, m_busy = 1'b0, m_done = 1'b0, m_dbz = 1'b0;
    logic [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
    logic        p_dbz = 1'b0;
    int          done_at = 0;

    always @(posedge clk) begin
        logic [31:0] rh, rl;
        logic        rz;
        ref_calc(op, srcA, srcB, rh, rl, rz);
        cyc    <= cyc + 1;
        m_done <= 1'b0;
        if (rst) begin
            m_valid   <= 1'b1;
            m_pending <= 1'b0;
            m_busy    <= 1'b0;
            m_hi      <= '0;
            m_lo      <= '0;
            m_dbz     <= 1'b0;
        end else if (flush) begin
            m_pending <= 1'b0;
            m_busy    <= 1'b0;
        end else if (m_pending) begin
            if (cyc + 1 == done_at) begin
                m_pending <= 1'b0;
                m_busy    <= 1'b0;
                m_done    <= 1'b1;
                m_hi      <= p_hi;
                m_lo      <= p_lo;
                m_dbz     <= p_dbz;
            end
        end else if (start) begin
            m_pending <= 1'b1;
            m_busy    <= 1'b1;
            done_at   <= cyc + 1 + (rz ? 1 : XLEN + 1);
            p_hi      <= rh;
            p_lo      <= rl;
            p_dbz     <= rz;
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            check("busy", 64'(busy), 64'(m_busy));
            check("done", 64'(done), 64'(m_done));
            check("hi", 64'(hi), 64'(m_hi));
            check("lo", 64'(lo), 64'(m_lo));
            if (m_done) check("div_by_zero", 64'(div_by_zero), 64'(m_dbz));
        end
    end

    // Called at the falling edge of the first cycle after the start edge.
    task automatic wait_done(input string name, input logic [31:0] eh, input logic [31:0] el,
                             input logic ez, input int lat);
        int j     = 1;
        int nbusy = 0;
        bit seen  = 1'b0;
        while (!seen && j <= 100) begin
            if (done) begin
                seen = 1'b1;
            end else begin
                if (busy) nbusy++;
                @(negedge clk);
                j++;
            end
        end
        check({name, " done_seen"}, 64'(seen), 64'd1);
        if (seen) begin
            check({name, " latency"}, 64'(j), 64'(lat));
            check({name, " busy_cycles"}, 64'(nbusy), 64'(lat - 1));
            check({name, " busy_at_done"}, 64'(busy), 64'd0);
            check({name, " hi"}, 64'(hi), 64'(eh));
            check({name, " lo"}, 64'(lo), 64'(el));
            check({name, " dbz"}, 64'(div_by_zero), 64'(ez));
        end
    endtask

    task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] eh, input logic [31:0] el, input logic ez, input int lat,
                          input bit now);
        if (!now) @(negedge clk);
        start = 1'b1;
        op    = o;
        srcA  = a;
        srcB  = b;
        @(negedge clk);
        start = 1'b0;
        srcA  = $urandom;
        srcB  = $urandom;
        op    = 2'($urandom);
        wait_done(name, eh, el, ez, lat);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'h0000_0001;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int ndone;
        repeat (2) @(negedge clk);
        check("reset busy", 64'(busy), 64'd0);
        check("reset done", 64'(done), 64'd0);
        check("reset dbz", 64'(div_by_zero), 64'd0);
        check("reset hi", 64'(hi), 64'd0);
        check("reset lo", 64'(lo), 64'd0);
        rst = 1'b0;

        run_op("multu", 2'b00, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001, 32'hFFFF_FFFE, 1'b0, 34, 1'b0);
        run_op("mult", 2'b01, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 34, 1'b0);
        run_op("div", 2'b11, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 34, 1'b0);
        // Started in the very cycle the previous done is high.
        run_op("divu", 2'b10, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 34, 1'b1);

`ifdef MULDIV_FLUSH_EN
        @(negedge clk);
        start = 1'b1; op = 2'b11; srcA = 32'd1000; srcB = 32'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush busy", 64'(busy), 64'd0);
        check("flush done", 64'(done), 64'd0);
        check("flush hi_kept", 64'(hi), 64'd2);
        check("flush lo_kept", 64'(lo), 64'd14);
        start = 1'b1; op = 2'b01; srcA = 32'hFFFF_FFFE; srcB = 32'd5;
        @(negedge clk);
        start = 1'b0;
        wait_done("flush_restart", 32'hFFFF_FFFF, 32'hFFFF_FFF6, 1'b0, 34);
`endif

        run_op("divu_by_zero", 2'b10, 32'h0000_1234, 32'd0, 32'h0000_1234, 32'hFFFF_FFFF, 1'b1, 2, 1'b0);
        run_op("div_overflow", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0, 34, 1'b0);

        // Reset in the middle of a multiply, with a stray start pulse before it.
        @(negedge clk);
        start = 1'b1; op = 2'b00; srcA = 32'h1234_5678; srcB = 32'h9ABC_DEF0;
        @(negedge clk);
        start = 1'b0;
        for (int j = 2; j <= 10; j++) begin
            @(negedge clk);
            start = (j == 5);
            op    = 2'b10;
            srcA  = $urandom;
            srcB  = $urandom;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midreset busy", 64'(busy), 64'd0);
        check("midreset done", 64'(done), 64'd0);
        check("midreset dbz", 64'(div_by_zero), 64'd0);
        check("midreset hi", 64'(hi), 64'd0);
        check("midreset lo", 64'(lo), 64'd0);
        ndone = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("midreset no_done", 64'(ndone), 64'd0);

        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            start = ($urandom_range(0, 3) == 0);
            op    = 2'($urandom);
            srcA  = pick();
            srcB  = pick();
`ifdef MULDIV_FLUSH_EN
            flush = ($urandom_range(0, 63) == 0);
`endif
        end
        @(negedge clk);
        start = 1'b0;
        flush = 1'b0;
        repeat (40) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
